ascon_p_ctrl: RTL

ASCON_P_CTRL -- requirements
Module: ascon_p_ctrl

---
 rtl/ascon_p_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ascon_p_ctrl.sv
// Sequencing controller for an external Ascon-p12 permutation datapath.
// Loads five BW-bit words into the datapath state and runs the 12 rounds.
// Then streams the five result words out, with a watchdog on the round phase.
//
// Handshakes: a word moves on a channel only on a rising clock edge where
// valid and ready are both high. Valid never waits for ready. Data and last
// are held stable while valid is high and ready is low.
module ascon_p_ctrl #(
    parameter int BW      = 64,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          s_valid,
    output logic          s_ready,
    input  logic [BW-1:0] s_data,

    output logic          m_valid,
    input  logic          m_ready,
    output logic [BW-1:0] m_data,
    output logic          m_last,

    output logic          busy,
    output logic          err,

    output logic          p_clr_n,
    output logic          p_en,
    output logic          p_en_inc,
    output logic [2:0]    p_slice_idx,
    output logic [BW-1:0] p_slice_in,
    input  logic [BW-1:0] p_slice_out,
    input  logic          p_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOAD   = 3'd2,
        PERM   = 3'd3,
        RD_SET = 3'd4,
        RD_OUT = 3'd5
    } state_t;

    // Watchdog value seen during the TIMEOUT-th PERM cycle. If p_done is
    // still low in that cycle, the job is abandoned.
    localparam logic [3:0] WD_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    logic [2:0] k;
    logic [3:0] wd;

    logic load_acc;
    logic rd_acc;
    logic perm_timeout;

    // Qualified events for the current cycle, decoded from registered state.
    always_comb begin
        load_acc     = 1'b0;
        rd_acc       = 1'b0;
        perm_timeout = 1'b0;
        if (state == LOAD) begin
            load_acc = s_valid & s_ready;
        end
        if (state == RD_OUT) begin
            rd_acc = m_valid & m_ready;
        end
        if (state == PERM) begin
            perm_timeout = ~p_done && (wd == WD_LAST);
        end
    end

    // Datapath strobes and pass-through data.
    // These must react in the same cycle to s_valid and p_done.
    // p_en is only possible while s_ready is high, which happens only in LOAD.
    // p_en_inc only fires in PERM, so the two strobes can never overlap.
    // m_data is gated by m_valid, so no stale slice is visible outside RD_OUT.
    always_comb begin
        p_en       = load_acc;
        p_en_inc   = (state == PERM) && ~p_done && ~perm_timeout;
        p_slice_in = (state == LOAD) ? s_data : '0;
        m_data     = m_valid ? p_slice_out : '0;
    end

    // Main FSM with registered handshake, status and slice-select outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            k           <= 3'd0;
            wd          <= 4'd0;
            err         <= 1'b0;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            p_slice_idx <= 3'd0;
            p_clr_n     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Release the datapath clear left over from reset.
                    // The first word is only consumed once LOAD is reached.
                    p_clr_n     <= 1'b1;
                    p_slice_idx <= 3'd0;
                    if (s_valid) begin
                        state   <= CLR;
                        p_clr_n <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                CLR: begin
                    // One-cycle re-arm of the datapath state and round counter.
                    // This stops a stale p_done from being seen when PERM starts.
                    err         <= 1'b0;
                    k           <= 3'd0;
                    p_clr_n     <= 1'b1;
                    p_slice_idx <= 3'd0;
                    s_ready     <= 1'b1;
                    state       <= LOAD;
                end

                LOAD: begin
                    // A missing s_valid simply stalls here.
                    // The slice index follows k so it is ready for the next accept.
                    if (load_acc) begin
                        if (k == 3'd4) begin
                            k           <= 3'd0;
                            wd          <= 4'd0;
                            s_ready     <= 1'b0;
                            p_slice_idx <= 3'd0;
                            state       <= PERM;
                        end else begin
                            k           <= k + 3'd1;
                            p_slice_idx <= k + 3'd1;
                        end
                    end
                end

                PERM: begin
                    wd <= wd + 4'd1;
                    if (p_done) begin
                        p_slice_idx <= k;
                        state       <= RD_SET;
                    end else if (perm_timeout) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                RD_SET: begin
                    // The datapath has one cycle of read latency.
                    // The slice selected during this cycle is presented in RD_OUT.
                    m_valid <= 1'b1;
                    m_last  <= (k == 3'd4);
                    state   <= RD_OUT;
                end

                RD_OUT: begin
                    // p_slice_idx is left alone under backpressure.
                    // This keeps the re-read slice, and so m_data, unchanged.
                    if (rd_acc) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (k == 3'd4) begin
                            k           <= 3'd0;
                            p_slice_idx <= 3'd0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            k           <= k + 3'd1;
                            p_slice_idx <= k + 3'd1;
                            state       <= RD_SET;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    k           <= 3'd0;
                    s_ready     <= 1'b0;
                    m_valid     <= 1'b0;
                    m_last      <= 1'b0;
                    busy        <= 1'b0;
                    p_slice_idx <= 3'd0;
                    p_clr_n     <= 1'b1;
                end
            endcase
        end
    end

endmodule
